// File: rtl/dz_decode_if.sv
// Scan-side and result-side signals of the dot-matrix digit decoder.
// The decoder is the slave; the scan driver / result consumer is the master.
interface dz_decode_if;
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic [2:0] num;
    logic [1:0] color;
    logic       match;
    logic       frame_valid;
    logic       seq_err;

    modport master (
        output row, colr, colg,
        input  num, color, match, frame_valid, seq_err
    );

    modport slave (
        input  row, colr, colg,
        output num, color, match, frame_valid, seq_err
    );
endinterface

// File: rtl/dz_decode.sv
// Captures a scanned 8x8 red/green matrix and decodes it against
// the digit glyph table, reporting digit, colour and scan-order errors.
module dz_decode (
    input  logic   clk,
    input  logic   rst,
    dz_decode_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE} state_t;

    state_t      state, nstate;
    logic [7:0]  row_q, colr_q, colg_q;
    logic [63:0] red_p, grn_p;
    logic [63:0] snap_r, snap_g;
    logic [2:0]  exp_q, exp_d;
    logic [7:0]  low;
    logic [2:0]  idx;
    logic        blank, onehot;
    logic        wr, err, snap;
    logic        pend, err_hold, err_any;
    logic [2:0]  num_q;
    logic [1:0]  color_q;
    logic        match_q, fv_q, serr_q;
    logic [63:0] lit;
    logic        any_r, any_g;
    logic [2:0]  dec_num;
    logic [1:0]  dec_col;
    logic        dec_match;

    // Glyph rows packed row 7 in the top byte, row 0 (always blank) at the bottom.
    function automatic logic [63:0] glyph(input logic [2:0] d);
        unique case (d)
            3'd0:    glyph = 64'h3C66_6666_6666_3C00;
            3'd1:    glyph = 64'h3C18_1818_1838_1800;
            3'd2:    glyph = 64'h3C66_300C_0666_3C00;
            3'd3:    glyph = 64'h3C66_061C_0666_3C00;
            3'd4:    glyph = 64'h0C0C_7E4C_2C1C_0C00;
            3'd5:    glyph = 64'h3C66_0606_7C60_7E00;
            default: glyph = 64'h0;
        endcase
    endfunction

    function automatic logic [1:0] gcol(input logic [2:0] d);
        unique case (d)
            3'd0, 3'd1: gcol = 2'd2;
            3'd2, 3'd3: gcol = 2'd3;
            3'd4, 3'd5: gcol = 2'd1;
            default:    gcol = 2'd0;
        endcase
    endfunction

    // Single input register stage; everything downstream uses these copies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q  <= 8'hFF;
            colr_q <= 8'h00;
            colg_q <= 8'h00;
        end else begin
            row_q  <= bus.row;
            colr_q <= bus.colr;
            colg_q <= bus.colg;
        end
    end

    // Classify the registered row: blank, legal one-cold index, or illegal.
    always_comb begin
        low    = ~row_q;
        blank  = (row_q == 8'hFF);
        onehot = (low != 8'h00) && ((low & (low - 8'd1)) == 8'h00);
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (low[i]) idx = 3'(i);
        end
    end

    // Scan-order tracking; COMPARE also consumes its sample as expected row 0.
    always_comb begin
        nstate = state;
        exp_d  = exp_q;
        wr     = 1'b0;
        err    = 1'b0;
        snap   = 1'b0;
        unique case (state)
            IDLE: begin
                if (onehot && idx == 3'd0) begin
                    nstate = CAPTURE;
                    exp_d  = 3'd0;
                    wr     = 1'b1;
                end
            end
            default: begin
                if (state == COMPARE) nstate = CAPTURE;
                if (blank) begin
                    nstate = CAPTURE;
                end else if (!onehot) begin
                    err    = 1'b1;
                    nstate = IDLE;
                end else if (idx == exp_q) begin
                    wr = 1'b1;
                end else if (exp_q != 3'd7 && idx == exp_q + 3'd1) begin
                    exp_d = exp_q + 3'd1;
                    wr    = 1'b1;
                end else if (exp_q == 3'd7 && idx == 3'd0) begin
                    nstate = COMPARE;
                    exp_d  = 3'd0;
                    wr     = 1'b1;
                    snap   = 1'b1;
                end else begin
                    err    = 1'b1;
                    nstate = IDLE;
                end
            end
        endcase
    end

    // State, expected row, colour planes and the completed-frame snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            exp_q  <= 3'd0;
            red_p  <= 64'h0;
            grn_p  <= 64'h0;
            snap_r <= 64'h0;
            snap_g <= 64'h0;
        end else begin
            state <= nstate;
            exp_q <= exp_d;
            if (snap) begin
                snap_r <= red_p;
                snap_g <= grn_p;
            end
            if (wr) begin
                red_p[{idx, 3'b000} +: 8] <= colr_q;
                grn_p[{idx, 3'b000} +: 8] <= colg_q;
            end
        end
    end

    // Colour classification and glyph lookup on the snapshot frame.
    always_comb begin
        lit       = snap_r | snap_g;
        any_r     = |snap_r;
        any_g     = |snap_g;
        dec_num   = 3'd0;
        dec_match = 1'b0;
        if (!any_r && !any_g)   dec_col = 2'd0;
        else if (snap_r == snap_g) dec_col = 2'd3;
        else if (!any_g)        dec_col = 2'd1;
        else if (!any_r)        dec_col = 2'd2;
        else                    dec_col = 2'd0;
        for (int d = 0; d < 6; d++) begin
            if (lit == glyph(3'(d)) && dec_col == gcol(3'(d))) begin
                dec_match = 1'b1;
                dec_num   = 3'(d);
            end
        end
    end

    // Result registers; a seq_err colliding with frame_valid slips one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= 1'b0;
            err_hold <= 1'b0;
            num_q    <= 3'd0;
            color_q  <= 2'd0;
            match_q  <= 1'b0;
            fv_q     <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            pend     <= (state == COMPARE);
            fv_q     <= pend;
            serr_q   <= err_any & ~pend;
            err_hold <= err_any & pend;
            if (pend) begin
                num_q   <= dec_num;
                color_q <= dec_col;
                match_q <= dec_match;
            end
        end
    end

    assign err_any         = err | err_hold;
    assign bus.num         = num_q;
    assign bus.color       = color_q;
    assign bus.match       = match_q;
    assign bus.frame_valid = fv_q;
    assign bus.seq_err     = serr_q;
endmodule

// File: tb/tb_dz_decode.sv
// Testbench for dz_decode: directed scenarios plus randomized frames
// checked against a row-table reference model.
module tb_dz_decode;
    typedef logic [7:0] plane_t [8];

    logic clk = 1'b0;
    logic rst;
    dz_decode_if bus ();

    dz_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edges = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    int coll = 0;
    int fv_edges[$];
    int err_edges[$];
    logic [5:0] fv_out[$];

    plane_t gt [6];
    int gcol [6] = '{2, 2, 3, 3, 1, 1};
    plane_t zero = '{default: 8'h00};

    // Edge counter.
    always @(posedge clk) edges++;

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.frame_valid) begin
            fv_cnt++;
            fv_edges.push_back(edges);
            fv_out.push_back({bus.num, bus.color, bus.match});
        end
        if (bus.seq_err) begin
            err_cnt++;
            err_edges.push_back(edges);
        end
        if (bus.frame_valid && bus.seq_err) coll++;
    end

    task automatic clear_mon();
        fv_cnt = 0;
        err_cnt = 0;
        coll = 0;
        fv_edges.delete();
        err_edges.delete();
        fv_out.delete();
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] cr,
                         input logic [7:0] cg);
        bus.row = r;
        bus.colr = cr;
        bus.colg = cg;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rc(input int k);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << k);
    endfunction

    task automatic blanks(input int n);
        repeat (n) drive(8'hFF, 8'h00, 8'h00);
    endtask

    task automatic scan(input plane_t r, input plane_t g, input int dwell);
        for (int k = 0; k < 8; k++)
            repeat (dwell) drive(rc(k), r[k], g[k]);
    endtask

    task automatic do_reset();
        bus.row = 8'hFF;
        bus.colr = 8'h00;
        bus.colg = 8'h00;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        clear_mon();
    endtask

    task automatic model(input plane_t r, input plane_t g, output logic [5:0] o);
        bit anyr, anyg, same, m, eq;
        int c, n;
        anyr = 0; anyg = 0; same = 1; m = 0; n = 0;
        for (int k = 0; k < 8; k++) begin
            if (r[k] != 0) anyr = 1;
            if (g[k] != 0) anyg = 1;
            if (r[k] != g[k]) same = 0;
        end
        if (!anyr && !anyg) c = 0;
        else if (same) c = 3;
        else if (!anyg) c = 1;
        else if (!anyr) c = 2;
        else c = 0;
        for (int d = 0; d < 6; d++) begin
            eq = 1;
            for (int k = 0; k < 8; k++)
                if ((r[k] | g[k]) != gt[d][k]) eq = 0;
            if (eq && c == gcol[d]) begin
                m = 1;
                n = d;
            end
        end
        o = {n[2:0], c[1:0], m};
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.row = 8'h00;
        bus.colr = 8'hFF;
        bus.colg = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.num !== 3'd0) begin failures++; $display("FAIL reset_num got=%0d exp=0", bus.num); end
        checks++;
        if (bus.color !== 2'd0) begin failures++; $display("FAIL reset_color got=%0d exp=0", bus.color); end
        checks++;
        if (bus.match !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", bus.match); end
        checks++;
        if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
        checks++;
        if (bus.seq_err !== 1'b0) begin failures++; $display("FAIL reset_serr got=%b exp=0", bus.seq_err); end
        rst = 1'b1;
    endtask

    task automatic test_digit5_red();
        int e0, lat;
        logic [5:0] o;
        do_reset();
        scan(gt[5], zero, 4);
        e0 = edges + 1;
        drive(rc(0), 8'h00, 8'h00);
        blanks(6);
        lat = (fv_edges.size() > 0) ? fv_edges[0] - e0 : -1;
        o = (fv_out.size() > 0) ? fv_out[0] : 6'h3F;
        checks++;
        if (fv_cnt != 1) begin failures++; $display("FAIL d5_fv_count got=%0d exp=1", fv_cnt); end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL d5_latency got=%0d exp=3", lat); end
        checks++;
        if (o !== {3'd5, 2'd1, 1'b1}) begin failures++; $display("FAIL d5_out got=%h exp=%h", o, {3'd5, 2'd1, 1'b1}); end
    endtask

    task automatic test_back_to_back();
        int gap;
        logic [5:0] o0, o1;
        do_reset();
        scan(gt[3], gt[3], 1);
        scan(gt[3], gt[3], 1);
        drive(rc(0), 8'h00, 8'h00);
        blanks(6);
        gap = (fv_edges.size() > 1) ? fv_edges[1] - fv_edges[0] : -1;
        o0 = (fv_out.size() > 0) ? fv_out[0] : 6'h3F;
        o1 = (fv_out.size() > 1) ? fv_out[1] : 6'h3F;
        checks++;
        if (fv_cnt != 2) begin failures++; $display("FAIL b2b_fv_count got=%0d exp=2", fv_cnt); end
        checks++;
        if (gap != 8) begin failures++; $display("FAIL b2b_gap got=%0d exp=8", gap); end
        checks++;
        if (o0 !== {3'd3, 2'd3, 1'b1}) begin failures++; $display("FAIL b2b_out0 got=%h exp=%h", o0, {3'd3, 2'd3, 1'b1}); end
        checks++;
        if (o1 !== {3'd3, 2'd3, 1'b1}) begin failures++; $display("FAIL b2b_out1 got=%h exp=%h", o1, {3'd3, 2'd3, 1'b1}); end
    endtask

    task automatic test_seq_err();
        int e4, el;
        do_reset();
        scan(gt[5], zero, 2);
        drive(rc(0), 8'h00, 8'h00);
        blanks(6);
        clear_mon();
        drive(rc(0), 8'h00, 8'h00);
        drive(rc(1), 8'h3C, 8'h00);
        drive(rc(2), 8'h66, 8'h00);
        e4 = edges + 1;
        drive(rc(4), 8'h66, 8'h00);
        blanks(6);
        el = (err_edges.size() > 0) ? err_edges[0] - e4 : -1;
        checks++;
        if (err_cnt != 1) begin failures++; $display("FAIL serr_count got=%0d exp=1", err_cnt); end
        checks++;
        if (el < 1 || el > 2) begin failures++; $display("FAIL serr_timing got=%0d exp=1..2", el); end
        checks++;
        if (fv_cnt != 0) begin failures++; $display("FAIL serr_no_fv got=%0d exp=0", fv_cnt); end
        checks++;
        if ({bus.num, bus.color, bus.match} !== {3'd5, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL serr_retain got=%h exp=%h", {bus.num, bus.color, bus.match}, {3'd5, 2'd1, 1'b1});
        end
    endtask

    task automatic test_illegal_row();
        logic [5:0] o;
        do_reset();
        drive(rc(0), 8'h00, 8'h00);
        drive(rc(1), 8'h00, 8'h3C);
        drive(rc(2), 8'h00, 8'h66);
        drive(8'hFC, 8'h00, 8'h66);
        blanks(3);
        checks++;
        if (err_cnt != 1) begin failures++; $display("FAIL ill_serr got=%0d exp=1", err_cnt); end
        clear_mon();
        scan(zero, gt[0], 2);
        drive(rc(0), 8'h00, 8'h00);
        blanks(6);
        o = (fv_out.size() > 0) ? fv_out[0] : 6'h3F;
        checks++;
        if (fv_cnt != 1) begin failures++; $display("FAIL ill_fv got=%0d exp=1", fv_cnt); end
        checks++;
        if (o !== {3'd0, 2'd2, 1'b1}) begin failures++; $display("FAIL ill_out got=%h exp=%h", o, {3'd0, 2'd2, 1'b1}); end
    endtask

    task automatic test_digit4_green();
        logic [5:0] o;
        do_reset();
        scan(zero, gt[4], 2);
        drive(rc(0), 8'h00, 8'h00);
        blanks(6);
        o = (fv_out.size() > 0) ? fv_out[0] : 6'h3F;
        checks++;
        if (fv_cnt != 1) begin failures++; $display("FAIL d4g_fv got=%0d exp=1", fv_cnt); end
        checks++;
        if (o !== {3'd0, 2'd2, 1'b0}) begin failures++; $display("FAIL d4g_out got=%h exp=%h", o, {3'd0, 2'd2, 1'b0}); end
    endtask

    task automatic test_reset_midframe();
        logic [5:0] o;
        do_reset();
        for (int k = 0; k < 5; k++) repeat (2) drive(rc(k), 8'h00, gt[1][k]);
        drive(rc(5), 8'h00, gt[1][5]);
        rst = 1'b0;
        drive(rc(5), 8'h00, gt[1][5]);
        drive(rc(5), 8'h00, gt[1][5]);
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.num !== 3'd0) begin
            failures++;
            $display("FAIL mid_in_reset got=%b/%0d exp=0/0", bus.frame_valid, bus.num);
        end
        rst = 1'b1;
        drive(rc(6), 8'h00, gt[1][6]);
        drive(rc(7), 8'h00, gt[1][7]);
        drive(rc(0), 8'h00, 8'h00);
        blanks(6);
        checks++;
        if (fv_cnt != 0) begin failures++; $display("FAIL mid_no_fv got=%0d exp=0", fv_cnt); end
        scan(zero, gt[1], 1);
        drive(rc(0), 8'h00, 8'h00);
        blanks(6);
        o = (fv_out.size() > 0) ? fv_out[0] : 6'h3F;
        checks++;
        if (fv_cnt != 1) begin failures++; $display("FAIL mid_fv got=%0d exp=1", fv_cnt); end
        checks++;
        if (o !== {3'd1, 2'd2, 1'b1}) begin failures++; $display("FAIL mid_out got=%h exp=%h", o, {3'd1, 2'd2, 1'b1}); end
    endtask

    task automatic test_random();
        localparam int NF = 20;
        logic [5:0] expq[$];
        logic [5:0] e, o;
        plane_t pat, r, g;
        int d, mode, cs, kr, b, dw;
        do_reset();
        for (int f = 0; f < NF; f++) begin
            d = $urandom_range(0, 5);
            mode = $urandom_range(0, 3);
            cs = gcol[d];
            pat = gt[d];
            if (mode == 1) cs = $urandom_range(1, 3);
            if (mode == 3) begin
                kr = $urandom_range(0, 7);
                b = $urandom_range(0, 7);
                pat[kr][b] = ~pat[kr][b];
            end
            r = zero;
            g = zero;
            if (mode == 2) begin
                r = pat;
                g = pat;
                kr = $urandom_range(1, 7);
                b = $urandom_range(0, 7);
                g[kr][b] = ~g[kr][b];
            end else begin
                if (cs != 2) r = pat;
                if (cs != 1) g = pat;
            end
            model(r, g, e);
            expq.push_back(e);
            for (int k = 0; k < 8; k++) begin
                dw = $urandom_range(1, 3);
                repeat (dw) drive(rc(k), r[k], g[k]);
                if ($urandom_range(0, 3) == 0) blanks($urandom_range(1, 2));
            end
        end
        drive(rc(0), 8'h00, 8'h00);
        blanks(8);
        checks++;
        if (fv_cnt != NF) begin failures++; $display("FAIL rnd_fv_count got=%0d exp=%0d", fv_cnt, NF); end
        checks++;
        if (err_cnt != 0) begin failures++; $display("FAIL rnd_serr got=%0d exp=0", err_cnt); end
        checks++;
        if (coll != 0) begin failures++; $display("FAIL rnd_collide got=%0d exp=0", coll); end
        for (int f = 0; f < NF; f++) begin
            o = (fv_out.size() > f) ? fv_out[f] : 6'h3F;
            checks++;
            if (o !== expq[f]) begin
                failures++;
                $display("FAIL rnd_frame%0d got=%h exp=%h", f, o, expq[f]);
            end
        end
    endtask

    initial begin
        gt[0] = '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C};
        gt[1] = '{8'h00, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h3C};
        gt[2] = '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h66, 8'h3C};
        gt[3] = '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C};
        gt[4] = '{8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C};
        gt[5] = '{8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C};
        test_reset();
        test_digit5_red();
        test_back_to_back();
        test_seq_err();
        test_illegal_row();
        test_digit4_green();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dz_decode.md
DZ_DECODE -- requirements
Module: dz_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port row, input, 8 bits: row select, active-low one-hot; row index k when row == ~(1<<k); 8'hFF means blanking.
REQ-004 SHALL have port colr, input, 8 bits: red column data for the selected row; 1 means lit; bit7 is the leftmost column.
REQ-005 SHALL have port colg, input, 8 bits: green column data for the selected row; same encoding as colr.
REQ-006 SHALL have port num, output, 3 bits: decoded digit 0..5.
REQ-007 SHALL have port color, output, 2 bits: 0 blank, 1 red, 2 green, 3 yellow.
REQ-008 SHALL have port match, output, 1 bit: 1 when the last frame equals a table glyph.
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when num, color and match update.
REQ-010 SHALL have port seq_err, output, 1 bit: one-cycle pulse on a scan-order violation.

Function
REQ-011 SHALL register row, colr and colg once; all decoding uses the registered copies.
REQ-012 SHALL treat a registered row with two or more low bits as illegal.
REQ-013 SHALL store an 8x8 red plane and an 8x8 green plane.
- The stored entry for row k is the last colr/colg sampled while index k was held.
- A row may dwell for any number of cycles, including 1.
REQ-014 SHALL implement FSM IDLE, CAPTURE, COMPARE.
REQ-015 IDLE SHALL ignore all input until index 0 is seen, then go to CAPTURE with expected index 0.
REQ-016 CAPTURE SHALL handle each registered sample as follows:
- Same index as expected: stay.
- Index = expected+1 (expected < 7): advance expected.
- 8'hFF: ignore; hold the planes and the expected index.
- Index 0 while expected == 7: go to COMPARE and begin capturing the next frame's row 0.
- Any other index, or an illegal row: pulse seq_err, go to IDLE, keep outputs unchanged.
REQ-017 COMPARE SHALL last one cycle. It SHALL then pulse frame_valid and update outputs, and return to CAPTURE with expected index 0 (back-to-back frames).
REQ-018 SHALL decode color from the whole frame:
- No lit pixels: color 0.
- All lit pixels in red only: color 1.
- All lit pixels in green only: color 2.
- Red plane equals green plane: color 3.
- Mixed: color 0 with match 0.
REQ-019 SHALL match the lit pattern (red OR green) against this glyph table. Row 0 is 00 for every digit; rows 1..7 in hex:
- 0 green: 3C,66,66,66,66,66,3C
- 1 green: 18,38,18,18,18,18,3C
- 2 yellow: 3C,66,06,0C,30,66,3C
- 3 yellow: 3C,66,06,1C,06,66,3C
- 4 red: 0C,1C,2C,4C,7E,0C,0C
- 5 red: 7E,60,7C,06,06,66,3C
REQ-020 SHALL set match=1 only when both the pattern and the color equal a table entry; num then equals that digit.
REQ-021 On match=0, SHALL set num=0 and keep the color computed per REQ-018.
REQ-022 Latency: frame_valid SHALL assert exactly 3 clk edges after the edge at which the input row first presents index 0 following index 7.
REQ-023 seq_err and frame_valid SHALL never assert in the same cycle.

Reset
REQ-024 While rst=0: FSM=IDLE, num=0, color=0, match=0, frame_valid=0, seq_err=0, both planes cleared, input registers cleared to row=8'hFF and columns 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, capture restarts only at the next index 0.

Verification
REQ-026 Scan digit 5 in red, rows 0..7 for 4 cycles each, then row 0 -> frame_valid pulse, num=5, color=1, match=1, at the REQ-022 latency.
REQ-027 Scan digit 3 with colr=colg, 1 cycle per row, two frames back-to-back -> two frame_valid pulses 8 cycles apart, num=3, color=3, match=1.
REQ-028 Scan row indices 0,1,2,4 -> seq_err pulses once on the sample at index 4; no frame_valid; outputs retain their prior values.
REQ-029 Drive row=8'hFC (two rows low) during CAPTURE -> seq_err pulse, FSM to IDLE; the next full frame decodes correctly.
REQ-030 Scan digit 4 glyph in green -> frame_valid, num=0, color=2, match=0.
REQ-031 Pull rst low during row 5 of a frame, release, resume scan at row 6 -> no frame_valid until a full 0..7,0 sequence completes.
